spi_slave_rx: RTL

- Oversampled SPI receiver: the capture-side counterpart of the team's SPI shift-out masters.
- Samples chip-select, serial clock and data with the system clock.
- Assembles an MSB-first frame of 1..255 bits and hands it over as a right-aligned word with its bit count and a valid/ack handshake.
- Used for DUT-readback loopback and board-to-board links where a master drives SCLK at ≤ 1/4 of iClk.

---
 rtl/spi_slave_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver. Synchronizes CS/SCLK/MOSI into iClk,
// assembles an MSB-first frame of up to 255 bits, publishes it right-aligned
// with its bit count through a valid/ack handshake.
// Optional feature: define SPI_SLAVE_RX_ECHO_EN to echo the previous frame on oMISO.
module spi_slave_rx #(
  parameter int unsigned MAXWIDTH    = 128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iSClk,
  input  logic                iCS,
  input  logic                iMOSI,
  input  logic                iAck,
  output logic                oMISO,
  output logic [MAXWIDTH-1:0] oData,
  output logic [7:0]          oWidth,
  output logic                oValid,
  output logic                oOverflow,
  output logic                oOverrun,
  output logic                oBusy
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_IDLE   = 2'd1,
    S_SHIFT  = 2'd2
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_d, cs_d;
  logic [MAXWIDTH-1:0]     shift;
  logic [CW-1:0]           cnt;
  logic                    ovf;

  logic                    sclk_s_c, mosi_s_c, sclk_rise_c;
  logic [MAXWIDTH-1:0]     shift_c;
  logic [CW-1:0]           cnt_c;
  logic                    ovf_c;

  // Synchronizer chains plus one edge-detect flop; reset low so a held-low CS
  // cannot look like an idle bus right after reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], iSClk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], iCS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], iMOSI};
      sclk_d    <= sclk_s_c;
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s_c    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s_c    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s_c & ~sclk_d;

  // Shift/count values including any bit arriving this cycle, so a frame end
  // coinciding with the last SCLK edge still publishes that bit.
  always_comb begin
    shift_c = shift;
    cnt_c   = cnt;
    ovf_c   = ovf;
    if (sclk_rise_c) begin
      shift_c = {shift[MAXWIDTH-2:0], mosi_s_c};
      cnt_c   = (cnt == CW'(255)) ? cnt : cnt + CW'(1);
      if (cnt >= CW'(MAXWIDTH)) ovf_c = 1'b1;
    end
  end

  // Frame FSM with registered handshake outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= S_RESYNC;
      shift     <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      oData     <= '0;
      oWidth    <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
      oOverrun  <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      if (iAck && oValid) begin
        oValid   <= 1'b0;
        oOverrun <= 1'b0;
      end
      case (state)
        S_RESYNC: begin
          if (cs_d) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!cs_d) begin
            state <= S_SHIFT;
            shift <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            oBusy <= 1'b1;
          end
        end
        S_SHIFT: begin
          shift <= shift_c;
          cnt   <= cnt_c;
          ovf   <= ovf_c;
          if (cs_d) begin
            state <= S_IDLE;
            oBusy <= 1'b0;
            if (cnt_c != '0) begin
              oData     <= shift_c;
              oWidth    <= cnt_c;
              oOverflow <= ovf_c;
              oValid    <= 1'b1;
              if (oValid && !iAck) oOverrun <= 1'b1;
            end
          end
        end
        default: state <= S_RESYNC;
      endcase
    end
  end

`ifdef SPI_SLAVE_RX_ECHO_EN
  localparam int unsigned IW = $clog2(MAXWIDTH);

  logic [MAXWIDTH-1:0] echo;
  logic [CW-1:0]       idx;
  logic                echo_act;
  logic                sclk_fall_c;

  assign sclk_fall_c = ~sclk_s_c & sclk_d;

  function automatic logic echo_bit(input logic [MAXWIDTH-1:0] v, input logic [CW-1:0] i);
    echo_bit = (i < CW'(MAXWIDTH)) ? v[i[IW-1:0]] : 1'b0;
  endfunction

  // Echo of the previously published frame, MSB first, stepping on SCLK falls.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      echo     <= '0;
      idx      <= '0;
      echo_act <= 1'b0;
      oMISO    <= 1'b0;
    end else if (state == S_IDLE && !cs_d) begin
      echo     <= oData;
      idx      <= oWidth - CW'(1);
      echo_act <= (oWidth != '0);
      oMISO    <= (oWidth != '0) ? echo_bit(oData, oWidth - CW'(1)) : 1'b0;
    end else if (state == S_SHIFT) begin
      if (sclk_fall_c && echo_act) begin
        if (idx == '0) begin
          echo_act <= 1'b0;
          oMISO    <= 1'b0;
        end else begin
          idx   <= idx - CW'(1);
          oMISO <= echo_bit(echo, idx - CW'(1));
        end
      end
    end else begin
      echo_act <= 1'b0;
      oMISO    <= 1'b0;
    end
  end
`else
  assign oMISO = 1'b0;
`endif

endmodule
